// File: rtl/i2c_tof_target.sv
// I2C target with a byte register file, used as a ToF sensor stand-in.
// 16-bit register pointer (MSB first), sequential writes, random reads via
// repeated START, pointer auto-increment with 16-bit wrap. A host port can
// preload register contents at any time, including while reset is held.
`timescale 1ns/1ps
module i2c_tof_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h11,
  parameter int         DEPTH       = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_t,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG_H, REG_H_ACK, REG_L, REG_L_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_MACK
  } state_t;

  logic [7:0]  mem [DEPTH];

  // [0] first flop, [1] synchronised value, [2] previous synchronised value
  logic [2:0]  scl_sync, sda_sync;
  logic        scl_rise, scl_fall, start_det, stop_det, sda_s;

  state_t      state;
  logic [2:0]  cnt;
  logic [7:0]  sh;
  logic [15:0] ptr;
  logic        rw;
  logic        ph;       // ACK states: 0 = ACK not yet driven; MACK: 1 = master ACKed
  logic [7:0]  rx_byte;
  logic        ptr_ok, host_ok, commit;
  logic [7:0]  rd_byte;

  assign sda_s     = sda_sync[1];
  assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
  assign start_det =  scl_sync[1] &  scl_sync[2] & ~sda_sync[1] &  sda_sync[2];
  assign stop_det  =  scl_sync[1] &  scl_sync[2] &  sda_sync[1] & ~sda_sync[2];

  assign rx_byte = {sh[6:0], sda_s};
  assign ptr_ok  = {1'b0, ptr} < DEPTH_L;
  assign host_ok = {1'b0, host_addr} < DEPTH_L;
  assign rd_byte = ptr_ok ? mem[ptr[AW-1:0]] : 8'hFF;

  // The byte being committed on the 8th SCL rise of a data byte; gated by
  // reset so a held reset can never write the array from the I2C side.
  assign commit = reset & (state == WDATA) & scl_rise & (cnt == 3'd7);

  // Two-flop synchronisers plus one delay stage for edge detection; idle
  // bus level after reset so no spurious START/STOP is seen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl_i};
      sda_sync <= {sda_sync[1:0], sda_i};
    end
  end

  // Register array: host preload port and I2C commit port. The I2C write is
  // issued last so it takes precedence when both hit the same address.
  always_ff @(posedge clk) begin
    if (host_we && host_ok) mem[host_addr[AW-1:0]] <= host_wdata;
    if (commit && ptr_ok)   mem[ptr[AW-1:0]]       <= rx_byte;
  end

  // Protocol FSM. STOP and START override every state; sda_t otherwise only
  // moves on SCL falling edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      sda_t    <= 1'b1;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      cnt      <= '0;
      sh       <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      ph       <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      if (stop_det) begin
        state <= IDLE;
        sda_t <= 1'b1;
        busy  <= 1'b0;
      end else if (start_det) begin
        // Pointer is kept so a repeated START can read from it.
        state <= ADDR;
        cnt   <= '0;
        sda_t <= 1'b1;
      end else begin
        case (state)
          IDLE: ;

          ADDR: if (scl_rise) begin
            sh  <= rx_byte;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (rx_byte[7:1] == TARGET_ADDR) begin
                state <= ADDR_ACK;
                busy  <= 1'b1;
                rw    <= rx_byte[0];
                ph    <= 1'b0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end

          // Shared ACK handling: first fall drives low, second fall releases
          // (or presents the first read bit) and moves on.
          ADDR_ACK, REG_H_ACK, REG_L_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ph) begin
              sda_t <= 1'b0;
              ph    <= 1'b1;
            end else begin
              ph  <= 1'b0;
              cnt <= '0;
              if (state == ADDR_ACK && rw) begin
                state <= RDATA;
                sh    <= rd_byte;
                sda_t <= rd_byte[7];
              end else begin
                sda_t <= 1'b1;
                case (state)
                  ADDR_ACK:  state <= REG_H;
                  REG_H_ACK: state <= REG_L;
                  default:   state <= WDATA;
                endcase
              end
            end
          end

          REG_H: if (scl_rise) begin
            sh  <= rx_byte;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              ptr[15:8] <= rx_byte;
              state     <= REG_H_ACK;
            end
          end

          REG_L: if (scl_rise) begin
            sh  <= rx_byte;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              ptr[7:0] <= rx_byte;
              state    <= REG_L_ACK;
            end
          end

          // Out-of-range writes are dropped by the array but still reported
          // and ACKed.
          WDATA: if (scl_rise) begin
            sh  <= rx_byte;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              wr_valid <= 1'b1;
              wr_addr  <= ptr;
              wr_data  <= rx_byte;
              ptr      <= ptr + 16'd1;
              state    <= WDATA_ACK;
            end
          end

          // MSB was placed on entry; each later fall presents the next bit.
          RDATA: begin
            if (scl_rise) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                state <= RDATA_MACK;
                ph    <= 1'b0;
              end
            end else if (scl_fall) begin
              sda_t <= sh[6];
              sh    <= {sh[6:0], 1'b0};
            end
          end

          // Release for the master's ACK bit; after an ACK the next byte is
          // loaded from the already-incremented pointer on the following fall.
          RDATA_MACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ptr <= ptr + 16'd1;
                ph  <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else if (scl_fall) begin
              if (!ph) begin
                sda_t <= 1'b1;
              end else begin
                ph    <= 1'b0;
                cnt   <= '0;
                sh    <= rd_byte;
                sda_t <= rd_byte[7];
                state <= RDATA;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_tof_target.sv
// Directed bench for i2c_tof_target: a bit-level I2C master model on a
// wired-AND SDA line, a table of write/readback vectors, and hand-written
// sequences for the multi-cycle corner cases.
`timescale 1ns/1ps
module tb_i2c_tof_target;

  localparam int Q = 10;   // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        sda_t, wr_valid, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        sda_line;

  assign sda_line = sda_m & sda_t;

  always #5 clk = ~clk;

  i2c_tof_target #(.TARGET_ADDR(7'h11), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .scl_i(scl), .sda_i(sda_line), .sda_t(sda_t),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Commit log and SDA-drive counter, written only by this monitor.
  logic [23:0] wr_log [64];
  int          wr_n = 0;
  int          low_cnt = 0;
  always @(negedge clk) begin
    if (wr_valid && wr_n < 64) begin
      wr_log[wr_n] <= {wr_addr, wr_data};
      wr_n         <= wr_n + 1;
    end
    if (!sda_t) low_cnt <= low_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    b = sda_line; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      get_bit(bit_v);
      d[i] = bit_v;
    end
    put_bit(mack);
  endtask

  // START + write address + 16-bit pointer; nacks is OR of all ACK bits.
  task automatic set_ptr(input logic [15:0] a, output logic nacks);
    logic k0, k1, k2;
    i2c_start();
    write_byte(8'h22, k0);
    write_byte(a[15:8], k1);
    write_byte(a[7:0], k2);
    nacks = k0 | k1 | k2;
  endtask

  // Single-byte random read with NACK, then STOP.
  task automatic read1(input logic [15:0] a, output logic nacks, output logic [7:0] d);
    logic k0, k1;
    set_ptr(a, k0);
    i2c_start();
    write_byte(8'h23, k1);
    read_byte(1'b1, d);
    i2c_stop();
    nacks = k0 | k1;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_rd;
  } vec_t;

  initial begin
    vec_t        tbl [4];
    logic        nk, k, b;
    logic [7:0]  d;
    logic [2:0]  bits;
    int          n0, lc0, wt;

    tbl[0] = '{a: 16'h0042, d: 8'hC3, exp_rd: 8'hC3};
    tbl[1] = '{a: 16'h0080, d: 8'h01, exp_rd: 8'h01};
    tbl[2] = '{a: 16'h00FE, d: 8'h80, exp_rd: 8'h80};
    tbl[3] = '{a: 16'h0100, d: 8'h6D, exp_rd: 8'hFF};   // out of range

    // Reset, with a host preload of mem[0xFF]=0x55 while reset is held.
    repeat (3) @(negedge clk);
    host_addr = 16'h00FF; host_wdata = 8'h55; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    @(negedge clk);
    check("rst sda_t",    sda_t,    1'b1);
    check("rst wr_valid", wr_valid, 1'b0);
    check("rst wr_addr",  wr_addr,  16'h0000);
    check("rst wr_data",  wr_data,  8'h00);
    check("rst busy",     busy,     1'b0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Sequential write of A5 3C 7E from 0x0010.
    n0 = wr_n;
    i2c_start();
    write_byte(8'h22, k); check("seq addr ack", k, 1'b0);
    check("seq busy", busy, 1'b1);
    write_byte(8'h00, k); check("seq regh ack", k, 1'b0);
    write_byte(8'h10, k); check("seq regl ack", k, 1'b0);
    write_byte(8'hA5, k); check("seq d0 ack", k, 1'b0);
    write_byte(8'h3C, k); check("seq d1 ack", k, 1'b0);
    write_byte(8'h7E, k); check("seq d2 ack", k, 1'b0);
    i2c_stop();
    check("seq busy after stop", busy, 1'b0);
    check("seq commit count", wr_n - n0, 3);
    check("seq commit 0", wr_log[n0],   24'h0010A5);
    check("seq commit 1", wr_log[n0+1], 24'h00113C);
    check("seq commit 2", wr_log[n0+2], 24'h00127E);

    // Random read via repeated START.
    set_ptr(16'h0010, nk);
    i2c_start();
    write_byte(8'h23, k);
    check("rd acks", {nk, k}, 2'b00);
    read_byte(1'b0, d); check("rd byte0", d, 8'hA5);
    read_byte(1'b0, d); check("rd byte1", d, 8'h3C);
    read_byte(1'b1, d); check("rd byte2", d, 8'h7E);
    check("rd released after nack", sda_t, 1'b1);
    i2c_stop();

    // Address mismatch: never ACKed, never drives, never commits.
    n0 = wr_n; lc0 = low_cnt;
    i2c_start();
    write_byte(8'h24, k); check("mis addr nack", k, 1'b1);
    check("mis busy", busy, 1'b0);
    write_byte(8'h00, k); check("mis data nack", k, 1'b1);
    i2c_stop();
    check("mis sda never driven", low_cnt - lc0, 0);
    check("mis no commit", wr_n - n0, 0);

    // Table: single-byte write then readback.
    foreach (tbl[i]) begin
      n0 = wr_n;
      set_ptr(tbl[i].a, nk);
      write_byte(tbl[i].d, k);
      i2c_stop();
      check($sformatf("tbl%0d wr acks", i), {nk, k}, 2'b00);
      check($sformatf("tbl%0d commit n", i), wr_n - n0, 1);
      check($sformatf("tbl%0d commit", i), wr_log[n0], {tbl[i].a, tbl[i].d});
      read1(tbl[i].a, nk, d);
      check($sformatf("tbl%0d rd acks", i), nk, 1'b0);
      check($sformatf("tbl%0d rd data", i), d, tbl[i].exp_rd);
    end

    // Boundary read across 0x00FF -> 0x0100.
    set_ptr(16'h00FF, nk);
    i2c_start();
    write_byte(8'h23, k);
    check("bnd rd acks", {nk, k}, 2'b00);
    read_byte(1'b0, d); check("bnd rd 0xFF", d, 8'h55);
    read_byte(1'b1, d); check("bnd rd 0x100", d, 8'hFF);
    i2c_stop();

    // Pointer wrap on write: 0xFFFF then 0x0000.
    n0 = wr_n;
    set_ptr(16'hFFFF, nk);
    write_byte(8'hB1, k); check("wrap d0 ack", {nk, k}, 2'b00);
    write_byte(8'hB2, k); check("wrap d1 ack", k, 1'b0);
    i2c_stop();
    check("wrap commit 0", wr_log[n0],   24'hFFFFB1);
    check("wrap commit 1", wr_log[n0+1], 24'h0000B2);
    read1(16'h0000, nk, d);
    check("wrap mem0", d, 8'hB2);

    // Collision: host writes 0x11 to 0x0020 across the I2C commit of 0x99.
    n0 = wr_n;
    set_ptr(16'h0020, nk);
    for (int i = 7; i >= 1; i--) put_bit(1'(8'h99 >> i));
    sda_m = 1'b1; wait_q();
    host_addr = 16'h0020; host_wdata = 8'h11; host_we = 1'b1;
    scl = 1'b1;
    wt = 0;
    while (!wr_valid && wt < 40) begin
      @(negedge clk);
      wt++;
    end
    host_we = 1'b0;
    check("col commit seen", wr_valid, 1'b1);
    wait_q();
    scl = 1'b0; wait_q();
    get_bit(k);
    i2c_stop();
    check("col acks", {nk, k}, 2'b00);
    check("col commit", wr_log[n0], 24'h002099);
    read1(16'h0020, nk, d);
    check("col readback", d, 8'h99);

    // Reset pulse while the target drives the 4th bit of 0xA5 (a 0).
    set_ptr(16'h0010, nk);
    i2c_start();
    write_byte(8'h23, k);
    for (int i = 2; i >= 0; i--) begin
      get_bit(b);
      bits[i] = b;
    end
    check("mrst first bits", bits, 3'b101);
    check("mrst driving bit4", sda_t, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mrst sda released", sda_t, 1'b1);
    check("mrst busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    i2c_stop();
    n0 = wr_n;
    set_ptr(16'h0030, nk);
    write_byte(8'h5A, k);
    i2c_stop();
    check("mrst post wr acks", {nk, k}, 2'b00);
    check("mrst post commit", wr_log[n0], 24'h00305A);
    read1(16'h0030, nk, d);
    check("mrst post readback", d, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_tof_target.md
Name: i2c_tof_target

Overview:
- I2C target (responder) with a byte register file, addressed by a 16-bit register address sent MSB first.
- Acts as the bus-side counterpart of the ToF I2C initiator array.
- Used in simulation and in loopback builds as a ToF sensor stand-in; the host side can preload distance data.
- Supports single and sequential writes, random reads via repeated START, and pointer auto-increment.

Parameters:
- TARGET_ADDR, 7'h11, 7-bit I2C target address.
- DEPTH, 256, number of implemented byte registers, at addresses 0..DEPTH-1.

Ports:
- clk  in  1  system clock; must be at least 20x the SCL frequency.
- reset  in  1  synchronous, active-low (0 = reset).
- scl_i  in  1  SCL from the IOBUF output (target never drives SCL; no clock stretching).
- sda_i  in  1  SDA from the IOBUF output.
- sda_t  out  1  SDA tristate control: 1 = release (high-Z), 0 = drive low.
- host_we  in  1  host preload write enable.
- host_addr  in  16  host preload address.
- host_wdata  in  8  host preload data.
- wr_valid  out  1  one-cycle pulse when the I2C master commits a data byte.
- wr_addr  out  16  register address of the committed byte.
- wr_data  out  8  value of the committed byte.
- busy  out  1  high from address match until STOP, or until a START addressed to another target.

Behaviour:
- Reset values: sda_t=1, wr_valid=0, wr_addr=0, wr_data=0, busy=0; state IDLE; pointer=0. Memory contents are not cleared.
- Input sync: scl_i and sda_i each pass through a 2-FF synchroniser. Edges are detected on the synchronised copies.
- START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- START or repeated START in any state: go to ADDR, clear the bit counter, keep the pointer.
- STOP in any state: go to IDLE, sda_t=1, busy=0.
- Bit sampling: data is sampled on SCL rising edges, 8 bits MSB first.
- sda_t changes only on detected SCL falling edges, at most 1 clk after detection.
- States:
  - IDLE: wait for START.
  - ADDR: shift 7 address bits + R/W. On match, go to ADDR_ACK and set busy=1. On mismatch, go to IDLE with no ACK.
  - ADDR_ACK: drive 0 for one SCL period. Then go to RDATA if R/W=1, else REG_H.
  - REG_H / REG_H_ACK: receive the pointer MSB, then ACK.
  - REG_L / REG_L_ACK: receive the pointer LSB, then ACK.
  - WDATA / WDATA_ACK: receive a byte, then ACK.
    - On the 8th SCL rise, write to mem[pointer] if pointer < DEPTH; otherwise the write is discarded but still ACKed.
    - Pulse wr_valid with wr_addr=pointer and wr_data=byte, then increment the pointer.
    - Return to WDATA for further bytes.
  - RDATA: on entry, load mem[pointer] (8'hFF if pointer >= DEPTH) and shift it out MSB first.
    - Each bit is driven on the SCL fall; a 1 bit releases the line.
  - RDATA_MACK: release SDA and sample the master's ACK on SCL rise.
    - ACK (0): increment the pointer, go to RDATA.
    - NACK (1): go to IDLE with SDA released.
- Pointer arithmetic: 16-bit, wraps 16'hFFFF -> 16'h0000. Out-of-range handling applies at every access.
- Read latency: the first read bit appears on the SDA line within 3 clk of the SCL fall that ends the address ACK.
- Host port: host_we writes mem[host_addr] when host_addr < DEPTH.
  - On the same cycle and same address as an I2C commit, the I2C write wins.
  - The host port is active in every state, including during reset.
- Arbitration-safe: a target that is not addressed never drives SDA.
- Reset mid-transfer: on the next clk edge the block returns to reset values. The master sees SDA released and the following bits NACKed.

Test Plan:
- Sequential write: START, 0x22 (0x11<<1|W), 0x00, 0x10, bytes A5 3C 7E, STOP.
  - -> ACK on all 6 bytes.
  - -> wr_valid pulses three times with (0x0010,A5), (0x0011,3C), (0x0012,7E).
  - -> busy falls after STOP.
- Random read: write pointer 0x0010, repeated START, 0x23, read 3 bytes as ACK, ACK, NACK, STOP.
  - -> SDA returns A5 3C 7E.
  - -> SDA is released after the NACK.
- Address mismatch: START, 0x24.
  - -> no ACK; sda_t stays 1 for the whole transfer; busy=0; no wr_valid.
- Boundary: with DEPTH=256, set pointer 0x00FF (preloaded 0x55 via host_we), read 2 bytes.
  - -> 55 then FF.
  - Write pointer 0xFFFF, 2 bytes -> ACKed; wr_addr shows FFFF then 0000; mem[0] updated.
- Collision: host_we to 0x0020 with 0x11 in the same cycle as an I2C commit of 0x99 to 0x0020.
  - -> a later read of 0x0020 returns 0x99.
- Reset mid-read: assert reset=0 for 1 clk during the 4th bit of RDATA.
  - -> sda_t=1 on the next clk; state IDLE; a subsequent full transaction completes normally.
